// File: rtl/worldmap_port_arbiter.sv
// Round-robin arbiter sharing the worldmap RAM read port between the rojobot
// core (requester 0) and the display/icon logic (requester 1).
module worldmap_port_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 2,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic [DATA_W-1:0] data0,
  output logic              valid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [DATA_W-1:0] data1,
  output logic              valid1,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int unsigned TAIL = RD_LATENCY - 1;

  logic                  last;
  logic                  sel;
  logic                  win0;
  logic                  win1;
  logic                  pick;
  logic [RD_LATENCY-1:0] tag_v;
  logic [RD_LATENCY-1:0] tag_id;

  // Round-robin pick: on contention the requester not granted last time wins.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || last)) begin
        win0 = 1'b1;
      end else if (req1) begin
        win1 = 1'b1;
      end
    end
  end

  assign gnt0   = win0;
  assign gnt1   = win1;
  assign mem_en = win0 | win1;

  // Idle cycles keep steering the RAM address from the last granted requester.
  assign pick     = mem_en ? win1 : sel;
  assign mem_addr = pick ? addr1 : addr0;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      last   <= 1'b1;
      sel    <= 1'b0;
      tag_v  <= '0;
      tag_id <= '0;
      data0  <= '0;
      data1  <= '0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
    end else begin
      if (mem_en) begin
        last <= win1;
        sel  <= win1;
      end
      tag_v[0]  <= mem_en;
      tag_id[0] <= win1;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      // The tail tag lines up with mem_data for the read it tracks.
      valid0 <= tag_v[TAIL] & ~tag_id[TAIL];
      valid1 <= tag_v[TAIL] & tag_id[TAIL];
      if (tag_v[TAIL]) begin
        if (tag_id[TAIL]) begin
          data1 <= mem_data;
        end else begin
          data0 <= mem_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_worldmap_port_arbiter.sv
// Directed bench for worldmap_port_arbiter: one instance with RD_LATENCY=1 (a_*)
// and one with RD_LATENCY=3 (b_*), each fed by a RAM model returning addr[1:0].
module tb_worldmap_port_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_req0, a_req1, a_gnt0, a_gnt1, a_valid0, a_valid1, a_mem_en;
  logic [AW-1:0] a_addr0, a_addr1, a_mem_addr;
  logic [DW-1:0] a_data0, a_data1, a_mem_data;
  logic          b_rst, b_req0, b_req1, b_gnt0, b_gnt1, b_valid0, b_valid1, b_mem_en;
  logic [AW-1:0] b_addr0, b_addr1, b_mem_addr;
  logic [DW-1:0] b_data0, b_data1, b_mem_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2:0] qa[$];
  logic [2:0] qb[$];

  worldmap_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_a (
    .clk_in(clk), .reset(a_rst),
    .req0(a_req0), .addr0(a_addr0), .gnt0(a_gnt0), .data0(a_data0), .valid0(a_valid0),
    .req1(a_req1), .addr1(a_addr1), .gnt1(a_gnt1), .data1(a_data1), .valid1(a_valid1),
    .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_data(a_mem_data)
  );

  worldmap_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_b (
    .clk_in(clk), .reset(b_rst),
    .req0(b_req0), .addr0(b_addr0), .gnt0(b_gnt0), .data0(b_data0), .valid0(b_valid0),
    .req1(b_req1), .addr1(b_addr1), .gnt1(b_gnt1), .data1(b_data1), .valid1(b_valid1),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_data(b_mem_data)
  );

  // RAM models: data = addr[1:0], delivered 1 and 3 clocks after the address.
  logic [DW-1:0] a_rd;
  logic [DW-1:0] b_rd [3];
  always @(posedge clk) begin
    a_rd    <= a_mem_addr[1:0];
    b_rd[0] <= b_mem_addr[1:0];
    b_rd[1] <= b_rd[0];
    b_rd[2] <= b_rd[1];
  end
  assign a_mem_data = a_rd;
  assign b_mem_data = b_rd[2];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_assert++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid pulse must match the oldest expected {id, data}.
  always @(negedge clk) begin
    if (a_valid0 || a_valid1) begin
      chk("a_valid_excl", 32'(a_valid0 & a_valid1), 0);
      chk("a_sb_pending", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        logic [2:0] e;
        e = qa.pop_front();
        chk("a_sb_ret", 32'({a_valid1, a_valid1 ? a_data1 : a_data0}), int'(e));
      end
    end
    if (b_valid0 || b_valid1) begin
      chk("b_valid_excl", 32'(b_valid0 & b_valid1), 0);
      chk("b_sb_pending", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        logic [2:0] e;
        e = qb.pop_front();
        chk("b_sb_ret", 32'({b_valid1, b_valid1 ? b_data1 : b_data0}), int'(e));
      end
    end
  end

  initial begin
    a_rst = 1'b1; a_req0 = 1'b1; a_req1 = 1'b1; a_addr0 = '0; a_addr1 = '0;
    b_rst = 1'b1; b_req0 = 1'b1; b_req1 = 1'b1; b_addr0 = '0; b_addr1 = '0;

    // Reset held with both requests high
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_a_gnt", 32'({a_gnt0, a_gnt1}), 0);
      chk("rst_a_mem_en", 32'(a_mem_en), 0);
      chk("rst_a_valid", 32'({a_valid0, a_valid1}), 0);
      chk("rst_a_data", 32'({a_data0, a_data1}), 0);
      chk("rst_b_gnt", 32'({b_gnt0, b_gnt1, b_mem_en}), 0);
      chk("rst_b_out", 32'({b_valid0, b_valid1, b_data0, b_data1}), 0);
    end
    nxt();
    a_rst = 1'b0; a_req0 = 1'b0; a_req1 = 1'b0;
    b_rst = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0;
    @(negedge clk);
    chk("idle_a_mem_en", 32'(a_mem_en), 0);

    // Single read, latency 1
    nxt();
    a_req0 = 1'b1; a_addr0 = 14'h0123;
    qa.push_back({1'b0, 2'b11});
    @(negedge clk);
    chk("single_gnt0", 32'(a_gnt0), 1);
    chk("single_gnt1", 32'(a_gnt1), 0);
    chk("single_mem_en", 32'(a_mem_en), 1);
    chk("single_mem_addr", 32'(a_mem_addr), 'h123);
    nxt();
    a_req0 = 1'b0;
    @(negedge clk);
    chk("single_t1_valid0", 32'(a_valid0), 0);
    chk("single_t1_gnt0", 32'(a_gnt0), 0);
    nxt();
    @(negedge clk);
    chk("single_t2_valid0", 32'(a_valid0), 1);
    chk("single_t2_data0", 32'(a_data0), 3);
    chk("single_t2_valid1", 32'(a_valid1), 0);
    nxt();
    @(negedge clk);
    chk("single_t3_valid0", 32'(a_valid0), 0);
    chk("single_t3_hold", 32'(a_data0), 3);
    chk("single_t3_gnt1", 32'(a_gnt1), 0);

    // Contention right as reset drops: strict alternation starting with 0
    nxt();
    a_rst = 1'b1;
    nxt();
    a_rst = 1'b0; a_req0 = 1'b1; a_req1 = 1'b1; a_addr0 = 14'h0010; a_addr1 = 14'h0021;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) nxt();
      if (i == 8) begin
        a_req0 = 1'b0; a_req1 = 1'b0;
      end
      if (i < 8) qa.push_back((i % 2 == 1) ? 3'b101 : 3'b000);
      @(negedge clk);
      chk("cont_gnt0", 32'(a_gnt0), int'(i < 8 && i % 2 == 0));
      chk("cont_gnt1", 32'(a_gnt1), int'(i < 8 && i % 2 == 1));
      if (i < 8) chk("cont_mem_addr", 32'(a_mem_addr), (i % 2 == 1) ? 'h21 : 'h10);
      if (i >= 2) begin
        chk("cont_valid0", 32'(a_valid0), int'(i % 2 == 0));
        chk("cont_valid1", 32'(a_valid1), int'(i % 2 == 1));
      end
    end
    chk("cont_data0", 32'(a_data0), 0);
    chk("cont_data1", 32'(a_data1), 1);

    // Fairness after idle: grant 0, idle, then both rise -> 1 then 0
    nxt();
    a_req0 = 1'b1; a_addr0 = 14'h0002;
    qa.push_back({1'b0, 2'b10});
    @(negedge clk);
    chk("fair_first_gnt0", 32'(a_gnt0), 1);
    nxt();
    a_req0 = 1'b0;
    repeat (2) nxt();
    nxt();
    a_req0 = 1'b1; a_req1 = 1'b1; a_addr1 = 14'h0005;
    qa.push_back({1'b1, 2'b01});
    @(negedge clk);
    chk("fair_gnt1_first", 32'({a_gnt1, a_gnt0}), 2);
    nxt();
    a_req1 = 1'b0;
    qa.push_back({1'b0, 2'b10});
    @(negedge clk);
    chk("fair_gnt0_second", 32'({a_gnt1, a_gnt0}), 1);
    nxt();
    a_req0 = 1'b0;
    repeat (4) nxt();

    // Pipelined returns, latency 3
    for (int i = 0; i < 9; i++) begin
      nxt();
      b_req1 = (i < 4);
      b_addr1 = 14'(i);
      if (i < 4) qb.push_back({1'b1, 2'(i)});
      @(negedge clk);
      chk("pipe_gnt1", 32'(b_gnt1), int'(i < 4));
      chk("pipe_valid1", 32'(b_valid1), int'(i >= 4 && i < 8));
      if (i >= 4 && i < 8) chk("pipe_data1", 32'(b_data1), i - 4);
    end

    // Reset while a latency-3 read is in flight
    nxt();
    b_req1 = 1'b0; b_req0 = 1'b1; b_addr0 = 14'h0003;
    @(negedge clk);
    chk("flight_gnt0", 32'(b_gnt0), 1);
    nxt();
    b_req0 = 1'b0; b_rst = 1'b1;
    @(negedge clk);
    chk("flight_rst_gnt", 32'({b_gnt0, b_mem_en}), 0);
    chk("flight_rst_valid0", 32'(b_valid0), 0);
    nxt();
    b_rst = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      if (k > 2) nxt();
      @(negedge clk);
      chk("flight_valid0", 32'(b_valid0), 0);
      chk("flight_data0", 32'(b_data0), 0);
    end

    chk("a_sb_drained", 32'(qa.size()), 0);
    chk("b_sb_drained", 32'(qb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/worldmap_port_arbiter.md
# worldmap_port_arbiter

Round-robin arbiter that shares the single read port of the worldmap block RAM between two requesters: the rojobot core (requester 0) and the display/icon logic (requester 1). It grants at most one read per clock and issues the address to the synchronous RAM. It tracks each in-flight read through a latency pipeline and returns data to the requester that issued it. Each requester's data output is held stable between its reads. The block sits between the two worldmap address/data port pairs and the worldmap RAM, in place of the hard-tied worldmap data lines.

## Interface
Parameters:
- ADDR_W, 14, worldmap address width
- DATA_W, 2, worldmap pixel/cell data width
- RD_LATENCY, 1, RAM read latency in clocks, legal 1..4

Ports:
- clk_in  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 read request, held until gnt0
- addr0  in  ADDR_W  requester 0 address, stable while req0 high
- gnt0  out  1  requester 0 request accepted this cycle
- data0  out  DATA_W  requester 0 last returned data, held
- valid0  out  1  one-cycle pulse: data0 updated this cycle
- req1, addr1, gnt1, data1, valid1: same as above, for requester 1
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM address
- mem_data  in  DATA_W  RAM read data, valid RD_LATENCY clocks after mem_en

## Operation
- Arbitration is combinational on req0/req1 and the registered priority pointer `last`, where last=0 means requester 0 was granted most recently.
  - Only one request high: that requester wins.
  - Both high: the requester not equal to `last` wins.
  - Neither high: no grant.
- Winner: its gntN=1, mem_en=1, mem_addr=addrN, all in the same cycle. The loser's gnt=0.
- With no grant: mem_en=0 and mem_addr holds its last granted value. mem_addr is driven from a mux select register, not a glitching default.
- `last` updates to the winner's index at the clock edge ending a granted cycle. It is unchanged when there is no grant.
- Tag pipeline: RD_LATENCY stages, each holding {v, id}. Stage 0 loads {mem_en, winner id}, and each stage shifts one stage per clock. The pipeline never stalls; the requesters cannot apply backpressure.
- When the last stage has v=1, mem_data is registered into data[id] and valid[id] is pulsed on the next cycle.
- The requester must drop reqN or present a new addrN in the cycle after gntN. A held reqN is treated as a new request.
- The arbiter does not compare or merge addresses. Duplicate reads are serviced twice.

## Timing
- Reset (synchronous, checked on clk_in edge) sets:
  - last=1, so requester 0 wins the first contention;
  - all pipeline v=0, discarding any in-flight reads;
  - valid0=valid1=0 and data0=data1=0;
  - the mem_addr select register to requester 0.
- While reset is high: gnt0=gnt1=0 and mem_en=0, regardless of the requests.
- Latency: grant in cycle t, mem_data sampled at the end of cycle t+RD_LATENCY, validN high in cycle t+RD_LATENCY+1. Total is RD_LATENCY+1 cycles.
- Throughput: one read per clock in aggregate.
  - Both requesters continuously requesting: strict alternation 0,1,0,1 after reset.
  - Maximum wait for any request: 1 cycle.
- Returns are in grant order. valid0 and valid1 are never both high in the same cycle.
- Reset asserted mid-operation: no valid pulse appears for any read granted before reset, including a read whose RAM data arrives after reset deasserts.
- A request arriving in the same cycle reset deasserts is eligible for a grant in the first cycle with reset=0.

## Test plan
- Reset check: reset high for 5 cycles with req0=req1=1 -> gnt0=gnt1=0, mem_en=0, valid0=valid1=0, data0=data1=0 throughout.
- Single read: RAM model returns addr[1:0]; RD_LATENCY=1; req0=1 with addr0=14'h0123 for one cycle t -> gnt0=1, mem_addr=14'h0123 at t; valid0=1, data0=2'b11 at t+2; data0 held after the pulse; gnt1 and valid1 never assert.
- Contention: req0 and req1 held high for 8 cycles, addr0=14'h0010, addr1=14'h0021 -> grant sequence 0,1,0,1,0,1,0,1; valid pulses follow the same order 2 cycles later; data0=2'b00, data1=2'b01.
- Pipelined returns: RD_LATENCY=3; req1 grants on 4 consecutive cycles t..t+3 with addr1=0,1,2,3 -> valid1 high t+4..t+7 with data1=0,1,2,3 in order.
- Reset mid-flight: RD_LATENCY=3; grant req0 at t; reset high during t+1 only -> no valid0 pulse through t+10; data0 remains 0.
- Fairness after idle: grant 0, then 3 idle cycles, then req0 and req1 rise together -> gnt1 first, then gnt0.
